// File: rtl/servile_wb_arbiter.sv
// Round-robin arbiter sharing the servile memory port between ibus and dbus.
// Define SERVILE_ARB_TIMEOUT_EN to add the hung-access watchdog.
module servile_wb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES  = 16,
  parameter logic        RESET_LAST_DBUS = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_wb_ibus_adr,
  input  logic        i_wb_ibus_stb,
  output logic [31:0] o_wb_ibus_rdt,
  output logic        o_wb_ibus_ack,
  input  logic [31:0] i_wb_dbus_adr,
  input  logic [31:0] i_wb_dbus_dat,
  input  logic [3:0]  i_wb_dbus_sel,
  input  logic        i_wb_dbus_we,
  input  logic        i_wb_dbus_stb,
  output logic [31:0] o_wb_dbus_rdt,
  output logic        o_wb_dbus_ack,
  output logic [31:0] o_wb_mem_adr,
  output logic [31:0] o_wb_mem_dat,
  output logic [3:0]  o_wb_mem_sel,
  output logic        o_wb_mem_we,
  output logic        o_wb_mem_stb,
  input  logic [31:0] i_wb_mem_rdt,
  input  logic        i_wb_mem_ack,
  output logic        o_err
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..255");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   last, last_nxt;
  logic   own_stb;
  logic   tmo;

  always_comb begin
    own_stb = 1'b0;
    if (state == GNT_I) own_stb = i_wb_ibus_stb;
    if (state == GNT_D) own_stb = i_wb_dbus_stb;
  end

`ifdef SERVILE_ARB_TIMEOUT_EN
  logic [7:0] cnt;

  // Ack wins over a watchdog expiry in the same cycle.
  assign tmo = own_stb && !i_wb_mem_ack &&
               (cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      cnt <= 8'd0;
    else if (state == IDLE || state_nxt == IDLE)
      cnt <= 8'd0;
    else
      cnt <= cnt + 8'd1;
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      last  <= RESET_LAST_DBUS;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    unique case (state)
      IDLE: begin
        if (i_wb_ibus_stb && (!i_wb_dbus_stb || last))
          state_nxt = GNT_I;
        else if (i_wb_dbus_stb)
          state_nxt = GNT_D;
      end
      GNT_I: begin
        if (i_wb_mem_ack || tmo) begin
          state_nxt = IDLE;
          last_nxt  = 1'b0;
        end else if (!i_wb_ibus_stb) begin
          state_nxt = IDLE;
        end
      end
      GNT_D: begin
        if (i_wb_mem_ack || tmo) begin
          state_nxt = IDLE;
          last_nxt  = 1'b1;
        end else if (!i_wb_dbus_stb) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_wb_mem_adr = i_wb_ibus_adr;
    o_wb_mem_dat = 32'd0;
    o_wb_mem_sel = 4'd0;
    o_wb_mem_we  = 1'b0;
    if (state == GNT_I) o_wb_mem_sel = 4'hf;
    if (state == GNT_D) begin
      o_wb_mem_adr = i_wb_dbus_adr;
      o_wb_mem_dat = i_wb_dbus_dat;
      o_wb_mem_sel = i_wb_dbus_sel;
      o_wb_mem_we  = i_wb_dbus_we;
    end
  end

  assign o_wb_mem_stb  = own_stb && !tmo;
  assign o_wb_ibus_ack = (state == GNT_I) && (i_wb_mem_ack || tmo);
  assign o_wb_dbus_ack = (state == GNT_D) && (i_wb_mem_ack || tmo);
  assign o_wb_ibus_rdt = tmo ? 32'd0 : i_wb_mem_rdt;
  assign o_wb_dbus_rdt = tmo ? 32'd0 : i_wb_mem_rdt;
  assign o_err         = tmo;

endmodule

// File: tb/tb_servile_wb_arbiter.sv
// Bench for servile_wb_arbiter: directed cases plus a randomized
// two-master run scored against a transaction-level arbitration model.
module tb_servile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ibus_adr = '0;
  logic        ibus_stb = 1'b0;
  logic [31:0] ibus_rdt;
  logic        ibus_ack;
  logic [31:0] dbus_adr = '0;
  logic [31:0] dbus_dat = '0;
  logic [3:0]  dbus_sel = '0;
  logic        dbus_we = 1'b0;
  logic        dbus_stb = 1'b0;
  logic [31:0] dbus_rdt;
  logic        dbus_ack;
  logic [31:0] mem_adr;
  logic [31:0] mem_dat;
  logic [3:0]  mem_sel;
  logic        mem_we;
  logic        mem_stb;
  logic [31:0] mem_rdt = '0;
  logic        mem_ack = 1'b0;
  logic        err;

  always #5 clk = ~clk;

  servile_wb_arbiter #(.TIMEOUT_CYCLES(16), .RESET_LAST_DBUS(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wb_ibus_adr(ibus_adr), .i_wb_ibus_stb(ibus_stb),
    .o_wb_ibus_rdt(ibus_rdt), .o_wb_ibus_ack(ibus_ack),
    .i_wb_dbus_adr(dbus_adr), .i_wb_dbus_dat(dbus_dat),
    .i_wb_dbus_sel(dbus_sel), .i_wb_dbus_we(dbus_we),
    .i_wb_dbus_stb(dbus_stb),
    .o_wb_dbus_rdt(dbus_rdt), .o_wb_dbus_ack(dbus_ack),
    .o_wb_mem_adr(mem_adr), .o_wb_mem_dat(mem_dat),
    .o_wb_mem_sel(mem_sel), .o_wb_mem_we(mem_we),
    .o_wb_mem_stb(mem_stb),
    .i_wb_mem_rdt(mem_rdt), .i_wb_mem_ack(mem_ack),
    .o_err(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  // Memory slave: random latency in auto mode, mirrors man_* otherwise.
  logic        slv_auto = 1'b0;
  logic        man_ack = 1'b0;
  logic [31:0] man_rdt = '0;
  int          wait_cnt = 0;
  int          lat = 0;

  initial forever begin
    @(posedge clk);
    #2;
    if (!slv_auto) begin
      mem_ack = man_ack;
      mem_rdt = man_rdt;
    end else if (mem_stb && wait_cnt >= lat) begin
      mem_ack  = 1'b1;
      mem_rdt  = f(mem_adr);
      wait_cnt = 0;
      lat      = $urandom_range(0, 3);
    end else begin
      mem_ack  = 1'b0;
      mem_rdt  = $urandom;
      wait_cnt = mem_stb ? wait_cnt + 1 : 0;
    end
  end

  // Reference model state and scoreboard queues.
  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];
  logic        mon_en = 1'b0;
  logic        last_served = 1'b1;
  logic        gnt_chk = 1'b0;
  logic        exp_owner = 1'b0;
  logic        ack_prev = 1'b0;
  logic        own_d = 1'b0;
  logic        i_done = 1'b0;
  logic        d_done = 1'b0;
  logic        i_busy = 1'b0;
  logic        d_busy = 1'b0;
  int          grants = 0;

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (gnt_chk) begin
        gnt_chk = 1'b0;
        chk("grant latency", 32'(mem_stb), 32'd1);
        if (mem_stb) chk("grant owner", 32'(mem_adr[31]), 32'(exp_owner));
        grants++;
      end
      if (ack_prev) chk("idle after ack", 32'(mem_stb), 32'd0);
      ack_prev = 1'b0;
      chk("err", 32'(err), 32'd0);
      own_d = mem_adr[31];
      if (mem_stb && own_d) begin
        chk("d adr", mem_adr, dbus_adr);
        chk("d dat", mem_dat, dbus_dat);
        chk("d sel", 32'(mem_sel), 32'(dbus_sel));
        chk("d we", 32'(mem_we), 32'(dbus_we));
      end else if (mem_stb) begin
        chk("i adr", mem_adr, ibus_adr);
        chk("i dat", mem_dat, 32'd0);
        chk("i sel", 32'(mem_sel), 32'hf);
        chk("i we", 32'(mem_we), 32'd0);
      end
      if (mem_stb && mem_ack) begin
        ack_prev = 1'b1;
        chk("ack route", {30'd0, ibus_ack, dbus_ack},
            own_d ? 32'd1 : 32'd2);
        if (!own_d) begin
          if (exp_i.size() == 0) chk("i queue", 32'd0, 32'd1);
          else chk("i rdt", ibus_rdt, exp_i.pop_front());
          i_done = 1'b1;
          last_served = 1'b0;
        end else begin
          if (exp_d.size() == 0) chk("d queue", 32'd0, 32'd1);
          else chk("d rdt", dbus_rdt, exp_d.pop_front());
          d_done = 1'b1;
          last_served = 1'b1;
        end
      end else begin
        chk("stray ack", {30'd0, ibus_ack, dbus_ack}, 32'd0);
      end
      // Arbitration decision for the next cycle, from the pending requests.
      if (!mem_stb && (ibus_stb || dbus_stb)) begin
        gnt_chk   = 1'b1;
        exp_owner = (ibus_stb && dbus_stb) ? !last_served : dbus_stb;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic masters(input bit force_req);
    logic [31:0] r;
    if (i_done) begin i_done = 1'b0; i_busy = 1'b0; ibus_stb = 1'b0; end
    if (d_done) begin d_done = 1'b0; d_busy = 1'b0; dbus_stb = 1'b0; end
    if (!i_busy && (force_req || $urandom_range(0, 2) == 0)) begin
      r = $urandom;
      ibus_adr = {1'b0, r[30:2], 2'b00};
      ibus_stb = 1'b1;
      i_busy   = 1'b1;
      exp_i.push_back(f(ibus_adr));
    end
    if (!d_busy && (force_req || $urandom_range(0, 2) == 0)) begin
      r = $urandom;
      dbus_adr = {1'b1, r[30:0]};
      dbus_dat = $urandom;
      dbus_sel = r[3:0];
      dbus_we  = r[4];
      dbus_stb = 1'b1;
      d_busy   = 1'b1;
      exp_d.push_back(f(dbus_adr));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    ibus_adr = 32'h0000_1234;
    sample();
    chk("rst stb", 32'(mem_stb), 32'd0);
    chk("rst acks", {30'd0, ibus_ack, dbus_ack}, 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst adr", mem_adr, 32'h0000_1234);
    chk("rst sel", 32'(mem_sel), 32'd0);
    chk("rst we", 32'(mem_we), 32'd0);
    chk("rst dat", mem_dat, 32'd0);

    // Single ibus read: request in cycle 0, ack in cycle 2.
    step(); rst_n = 1'b1;
    step(); ibus_stb = 1'b1; ibus_adr = 32'h0000_0040;
    sample(); chk("t1 c0 stb", 32'(mem_stb), 32'd0);
    step();
    sample();
    chk("t1 c1 stb", 32'(mem_stb), 32'd1);
    chk("t1 c1 adr", mem_adr, 32'h0000_0040);
    chk("t1 c1 we", 32'(mem_we), 32'd0);
    chk("t1 c1 ack", 32'(ibus_ack), 32'd0);
    step(); man_ack = 1'b1; man_rdt = 32'h0000_0013;
    sample();
    chk("t1 c2 stb", 32'(mem_stb), 32'd1);
    chk("t1 c2 iack", 32'(ibus_ack), 32'd1);
    chk("t1 c2 irdt", ibus_rdt, 32'h0000_0013);
    chk("t1 c2 dack", 32'(dbus_ack), 32'd0);
    step(); ibus_stb = 1'b0; man_ack = 1'b0;
    sample(); chk("t1 c3 stb", 32'(mem_stb), 32'd0);

    // Spurious ack while idle.
    step(); man_ack = 1'b1;
    sample();
    chk("spur acks", {30'd0, ibus_ack, dbus_ack}, 32'd0);
    chk("spur stb", 32'(mem_stb), 32'd0);
    step(); man_ack = 1'b0;
    sample(); chk("spur idle", 32'(mem_stb), 32'd0);

    // dbus write racing an ibus request; ibus was served last.
    step();
    dbus_adr = 32'h0000_0100; dbus_dat = 32'hdeadbeef;
    dbus_sel = 4'b0011; dbus_we = 1'b1; dbus_stb = 1'b1;
    ibus_adr = 32'h0000_0200; ibus_stb = 1'b1;
    sample(); chk("t3 arb stb", 32'(mem_stb), 32'd0);
    step(); sample();
    chk("t3 adr", mem_adr, 32'h0000_0100);
    chk("t3 dat", mem_dat, 32'hdeadbeef);
    chk("t3 sel", 32'(mem_sel), 32'h3);
    chk("t3 we", 32'(mem_we), 32'd1);
    step(); man_ack = 1'b1;
    sample();
    chk("t3 acks", {30'd0, ibus_ack, dbus_ack}, 32'd1);
    step(); man_ack = 1'b0; dbus_stb = 1'b0;
    sample(); chk("t3 idle", 32'(mem_stb), 32'd0);
    step(); sample();
    chk("t3 i stb", 32'(mem_stb), 32'd1);
    chk("t3 i adr", mem_adr, 32'h0000_0200);
    chk("t3 i sel", 32'(mem_sel), 32'hf);
    step(); man_ack = 1'b1;
    sample(); chk("t3 i ack", 32'(ibus_ack), 32'd1);
    step(); man_ack = 1'b0; ibus_stb = 1'b0;

    // Reset while dbus owns the port; tie afterwards must go to ibus.
    step(); dbus_we = 1'b0; dbus_stb = 1'b1; ibus_stb = 1'b1;
    step(); sample();
    chk("t4 gnt d", {31'd0, mem_stb & mem_adr[31:8] == 24'd1}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t4 async stb", 32'(mem_stb), 32'd0);
    chk("t4 async ack", {30'd0, ibus_ack, dbus_ack}, 32'd0);
    step(); rst_n = 1'b1;
    sample(); chk("t4 idle", 32'(mem_stb), 32'd0);
    step(); sample();
    chk("t4 tie stb", 32'(mem_stb), 32'd1);
    chk("t4 tie adr", mem_adr, 32'h0000_0200);
    step(); man_ack = 1'b1;
    step(); man_ack = 1'b0; ibus_stb = 1'b0; dbus_stb = 1'b0;

    // Randomized run; first stretch keeps both masters requesting.
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1;
    last_served = 1'b1;
    slv_auto = 1'b1;
    mon_en = 1'b1;
    for (int c = 0; c < 600; c++) begin
      step();
      masters(c < 60);
    end
    for (int c = 0; c < 60 && (i_busy || d_busy || i_done || d_done); c++) begin
      step();
      if (i_done) begin i_done = 1'b0; i_busy = 1'b0; ibus_stb = 1'b0; end
      if (d_done) begin d_done = 1'b0; d_busy = 1'b0; dbus_stb = 1'b0; end
    end
    step();
    chk("drain", {30'd0, i_busy, d_busy}, 32'd0);
    chk("queues", 32'(exp_i.size() + exp_d.size()), 32'd0);
    chk("grants seen", 32'(grants > 100), 32'd1);
    mon_en = 1'b0;
    slv_auto = 1'b0;
    man_ack = 1'b0;
    man_rdt = 32'hffff_ffff;
    step(); step();

    dbus_adr = 32'h8000_0010; dbus_we = 1'b0; dbus_stb = 1'b1;
    sample(); chk("w arb", 32'(mem_stb), 32'd0);
`ifdef SERVILE_ARB_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 2) begin ibus_adr = 32'h0000_0300; ibus_stb = 1'b1; end
      sample();
      if (k < 16) begin
        chk("tmo wait stb", 32'(mem_stb), 32'd1);
        chk("tmo wait ack", 32'(dbus_ack), 32'd0);
        chk("tmo wait err", 32'(err), 32'd0);
      end else begin
        chk("tmo dack", 32'(dbus_ack), 32'd1);
        chk("tmo drdt", dbus_rdt, 32'd0);
        chk("tmo err", 32'(err), 32'd1);
        chk("tmo stb", 32'(mem_stb), 32'd0);
        chk("tmo iack", 32'(ibus_ack), 32'd0);
      end
    end
    step(); dbus_stb = 1'b0;
    sample();
    chk("tmo idle", 32'(mem_stb), 32'd0);
    chk("tmo err off", 32'(err), 32'd0);
    step(); sample();
    chk("tmo next gnt", mem_adr, 32'h0000_0300);
    chk("tmo next stb", 32'(mem_stb), 32'd1);
    step(); man_ack = 1'b1;
    sample(); chk("tmo next ack", 32'(ibus_ack), 32'd1);
    step(); man_ack = 1'b0; ibus_stb = 1'b0;
`else
    for (int k = 1; k <= 24; k++) begin
      step(); sample();
    end
    chk("hold stb", 32'(mem_stb), 32'd1);
    chk("hold ack", 32'(dbus_ack), 32'd0);
    chk("hold err", 32'(err), 32'd0);
    step(); man_ack = 1'b1;
    sample();
    chk("hold dack", 32'(dbus_ack), 32'd1);
    chk("hold drdt", dbus_rdt, 32'hffff_ffff);
    step(); man_ack = 1'b0; dbus_stb = 1'b0;
`endif
    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
